psum_acc_ctrl: RTL and testbench
================================

PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning); clock and reset SHALL be clk and rst_n, reset synchronous, active-low:
  clk  in  1  clock
  rst_n  in  1  reset, synchronous, active-low
  cfg_start  in  1  one-cycle start pulse
  cfg_tile_len  in  13  psum words per tile, legal 1..4096
  cfg_tile_num  in  16  tiles per job
  cfg_identity_en  in  1  drive identity_sel on the accumulate pass
  mac_data_in  in  64  psum data from the MAC array
  mac_vld_in  in  1  MAC data valid
  mac_rdy_out  out  1  ready to the MAC array
  acc_info  out  32  info word to psum_acc
  acc_data  out  64  data to psum_acc
  acc_vld  out  1  valid to psum_acc
  acc_rdy  in  1  ready from psum_acc
  busy  out  1  job in progress
  done  out  1  one-cycle job-complete pulse
REQ-002 SHALL have no parameters; widths are fixed.

Function
REQ-003 SHALL implement an FSM with states IDLE, WR (first input-channel group), ACC (second group) and DONE.
REQ-004 SHALL, in IDLE with cfg_start=1, latch cfg_tile_len, cfg_tile_num and cfg_identity_en, clear addr_cnt and tile_cnt, and go to WR next cycle.
REQ-005 SHALL, if the latched tile_len or tile_num is 0, go from IDLE to DONE instead of WR, with zero transfers.
REQ-006 SHALL ignore cfg_start outside IDLE; the latched config stays stable for the whole job.
REQ-007 SHALL drive acc_vld = mac_vld_in & (WR|ACC), and mac_rdy_out = acc_rdy & (WR|ACC), both combinational, with zero-latency pass-through.
REQ-008 SHALL drive acc_data = mac_data_in, combinational.
REQ-009 SHALL drive acc_info: [11:0] = addr_cnt; [12] = 1 in ACC, else 0; [13] = cfg_identity_en latched & ACC; [31:14] = 0.
REQ-010 SHALL define a transfer as acc_vld & acc_rdy; only transfers advance addr_cnt.
REQ-011 SHALL, on a transfer with addr_cnt < tile_len-1, increment addr_cnt by 1.
REQ-012 SHALL, on a transfer with addr_cnt = tile_len-1, wrap addr_cnt to 0 and:
  - in WR, go to ACC;
  - in ACC with tile_cnt < tile_num-1, increment tile_cnt and go to WR;
  - in ACC with tile_cnt = tile_num-1, go to DONE.
REQ-013 SHALL handle tile_len=4096: addr_cnt reaches 4095 and wraps to 0; no 12-bit overflow aliasing.
REQ-014 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-015 SHALL drive busy=1 in WR, ACC and DONE, and busy=0 in IDLE.
REQ-016 SHALL let acc_vld/acc_info change only on state or counter updates; with acc_rdy=0, info and data SHALL hold while mac_vld_in holds.

Reset
REQ-017 SHALL, while rst_n=0 at a clk edge, set state=IDLE, addr_cnt=0, tile_cnt=0, all latched config to 0, and outputs busy=0, done=0, acc_vld=0, mac_rdy_out=0, acc_info=0.
REQ-018 SHALL, on reset mid-job, abort the job with no done pulse; the next cfg_start begins a fresh job.

Structure
REQ-019 SHALL place the FSM state encoding and the info-bit positions (ADDR_MSB=11, ACC_BIT=12, ID_BIT=13) in a shared package used by psum_acc_ctrl and its testbench.
REQ-020 SHALL be a single module with no sub-modules; it instantiates psum_acc at the next hierarchy level, not inside.

Verification
REQ-021 Scenario: tile_len=4, tile_num=1, identity_en=0, MAC always valid, acc_rdy=1 -> info addrs 0,1,2,3 with bit12=0, then 0,1,2,3 with bit12=1; done pulses 1 cycle after the 8th transfer.
REQ-022 Scenario: tile_len=3, tile_num=2, identity_en=1 -> pattern WR0-2, ACC0-2 (bit13=1), WR0-2, ACC0-2; 12 transfers; then done.
REQ-023 Scenario: acc_rdy toggles randomly, mac_vld_in bursty -> exactly 2*len*num transfers; acc_info stable while acc_vld=1 & acc_rdy=0; scoreboard matches.
REQ-024 Scenario: tile_len=0 or tile_num=0 -> no acc_vld; done asserted 2 cycles after cfg_start; busy high 1 cycle.
REQ-025 Scenario: cfg_start pulsed again mid-job with different config -> ignored; original sequence completes unchanged.
REQ-026 Scenario: rst_n=0 during ACC at addr 5, then restart with tile_len=4096, tile_num=1 -> no done from the aborted job; addr reaches 4095 then wraps; 8192 transfers; done.

Source files
------------

// File: rtl/psum_acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// psum_acc_ctrl_pkg
// Shared FSM encoding and info-word bit positions for psum_acc_ctrl.
// Rev 1.0 - initial release
// ============================================================================
package psum_acc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Field positions inside the 32-bit info word sent to psum_acc
    localparam int ADDR_MSB = 11;
    localparam int ACC_BIT  = 12;
    localparam int ID_BIT   = 13;

endpackage
`default_nettype wire

// File: rtl/psum_acc_ctrl.sv
`default_nettype none
// ============================================================================
// psum_acc_ctrl
// Sequences MAC partial sums into psum_acc: for each tile, one write pass
// (first input-channel group) followed by one accumulate pass (second group).
// Data and handshakes pass through combinationally; only the info word is
// generated here.
// Rev 1.0 - initial release
// ============================================================================
module psum_acc_ctrl
    import psum_acc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [12:0] cfg_tile_len,
    input  logic [15:0] cfg_tile_num,
    input  logic        cfg_identity_en,
    input  logic [63:0] mac_data_in,
    input  logic        mac_vld_in,
    output logic        mac_rdy_out,
    output logic [31:0] acc_info,
    output logic [63:0] acc_data,
    output logic        acc_vld,
    input  logic        acc_rdy,
    output logic        busy,
    output logic        done
);

    state_t      state;
    state_t      state_nxt;
    logic [11:0] addr_cnt;
    logic [11:0] addr_nxt;
    logic [15:0] tile_cnt;
    logic [15:0] tile_nxt;
    logic [12:0] len_q;
    logic [15:0] num_q;
    logic        id_q;

    logic        active;
    logic        xfer;
    logic        addr_last;
    logic        tile_last;

    // Streaming handshake: MAC and psum_acc are coupled only while a pass runs
    always_comb begin
        active      = (state == ST_WR) || (state == ST_ACC);
        acc_vld     = mac_vld_in & active;
        mac_rdy_out = acc_rdy & active;
        acc_data    = mac_data_in;
        xfer        = acc_vld & acc_rdy;
        // Compare in 13 bits so a 4096-word tile ends at address 4095
        addr_last   = ({1'b0, addr_cnt} == (len_q - 13'd1));
        tile_last   = (tile_cnt == (num_q - 16'd1));

        acc_info                 = '0;
        acc_info[ADDR_MSB:0]     = addr_cnt;
        acc_info[ACC_BIT]        = (state == ST_ACC);
        acc_info[ID_BIT]         = id_q & (state == ST_ACC);

        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Next-state and counter update logic
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_cnt;
        tile_nxt  = tile_cnt;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    addr_nxt = '0;
                    tile_nxt = '0;
                    // An empty job completes immediately without transfers
                    if ((cfg_tile_len == 13'd0) || (cfg_tile_num == 16'd0)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (xfer) begin
                    if (addr_last) begin
                        addr_nxt  = '0;
                        state_nxt = ST_ACC;
                    end else begin
                        addr_nxt = addr_cnt + 12'd1;
                    end
                end
            end
            ST_ACC: begin
                if (xfer) begin
                    if (addr_last) begin
                        addr_nxt = '0;
                        if (tile_last) begin
                            state_nxt = ST_DONE;
                        end else begin
                            tile_nxt  = tile_cnt + 16'd1;
                            state_nxt = ST_WR;
                        end
                    end else begin
                        addr_nxt = addr_cnt + 12'd1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and job configuration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr_cnt <= '0;
            tile_cnt <= '0;
            len_q    <= '0;
            num_q    <= '0;
            id_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_cnt <= addr_nxt;
            tile_cnt <= tile_nxt;
            // Config is captured only when a job is accepted
            if ((state == ST_IDLE) && cfg_start) begin
                len_q <= cfg_tile_len;
                num_q <= cfg_tile_num;
                id_q  <= cfg_identity_en;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_acc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_psum_acc_ctrl
// Self-checking bench for psum_acc_ctrl: vector table of jobs plus
// hand-written reset and long-tile sequences.
// Rev 1.0 - initial release
// ============================================================================
module tb_psum_acc_ctrl;
    import psum_acc_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic [12:0] cfg_tile_len;
    logic [15:0] cfg_tile_num;
    logic        cfg_identity_en;
    logic [63:0] mac_data_in;
    logic        mac_vld_in;
    logic        mac_rdy_out;
    logic [31:0] acc_info;
    logic [63:0] acc_data;
    logic        acc_vld;
    logic        acc_rdy;
    logic        busy;
    logic        done;

    int total;
    int bad;

    psum_acc_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start       (cfg_start),
        .cfg_tile_len    (cfg_tile_len),
        .cfg_tile_num    (cfg_tile_num),
        .cfg_identity_en (cfg_identity_en),
        .mac_data_in     (mac_data_in),
        .mac_vld_in      (mac_vld_in),
        .mac_rdy_out     (mac_rdy_out),
        .acc_info        (acc_info),
        .acc_data        (acc_data),
        .acc_vld         (acc_vld),
        .acc_rdy         (acc_rdy),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] len;
        logic [15:0] num;
        logic        id;
        bit          rnd;
        bit          mid;
        int          exp_xfers;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one job from cfg_start to done, checking every transfer against an
    // expected info sequence built from the tile/pass/address loops.
    task automatic run_job(input logic [12:0] len, input logic [15:0] num, input logic id,
                           input bit rnd, input bit mid, output int xfers);
        logic [31:0] expq[$];
        logic [31:0] e;
        logic [31:0] p_info;
        logic [63:0] p_data;
        int cyc, last_x, done_cyc, busy_bad, budget;
        bit stalled;

        expq.delete();
        for (int t = 0; t < int'(num); t++) begin
            for (int p = 0; p < 2; p++) begin
                for (int a = 0; a < int'(len); a++) begin
                    e = '0;
                    e[ADDR_MSB:0] = a[11:0];
                    e[ACC_BIT]    = p[0];
                    e[ID_BIT]     = id & p[0];
                    expq.push_back(e);
                end
            end
        end

        xfers = 0; cyc = 0; last_x = -10; done_cyc = -1; busy_bad = 0; stalled = 1'b0;
        p_info = '0; p_data = '0;
        budget = 16 * int'(len) * int'(num) + 20;

        while (done_cyc < 0 && cyc < budget) begin
            @(negedge clk);
            cfg_start = (cyc == 0) || (mid && cyc == 5);
            if (cyc == 0) begin
                cfg_tile_len = len; cfg_tile_num = num; cfg_identity_en = id;
            end else if (mid && cyc == 5) begin
                cfg_tile_len = len + 13'd5; cfg_tile_num = num + 16'd2; cfg_identity_en = ~id;
            end
            if (stalled) begin
                mac_vld_in = 1'b1;
            end else begin
                mac_vld_in  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                mac_data_in = {$urandom, $urandom};
            end
            acc_rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (stalled) begin
                chk("stall_info", {32'd0, acc_info}, {32'd0, p_info});
                chk("stall_data", acc_data, p_data);
            end
            if ((cyc == 0 && busy) || (cyc > 0 && !busy)) busy_bad++;
            if (acc_vld && acc_rdy) begin
                if (expq.size() == 0) begin
                    chk("extra_xfer", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("xfer_info", {32'd0, acc_info}, {32'd0, e});
                    chk("xfer_data", acc_data, mac_data_in);
                end
                xfers++;
                last_x = cyc;
            end
            stalled = acc_vld && !acc_rdy;
            p_info  = acc_info;
            p_data  = acc_data;
            if (done) done_cyc = cyc;
            cyc++;
        end

        cfg_start = 1'b0;
        if (done_cyc < 0) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            chk("left_xfers", 64'(expq.size()), 64'd0);
            if (len != 13'd0 && num != 16'd0)
                chk("done_latency", 64'(done_cyc - last_x), 64'd1);
            else
                chk("empty_done_by_2", 64'(done_cyc <= 2), 64'd1);
            chk("busy_window", 64'(busy_bad), 64'd0);
            @(negedge clk);
            mac_vld_in = 1'b0;
            #1;
            chk("done_one_cycle", {63'd0, done}, 64'd0);
            chk("idle_after_done", {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   x;
        bit   found, seen_done;

        total = 0; bad = 0;
        vecs[0] = '{13'd4, 16'd1, 1'b0, 1'b0, 1'b0, 8};
        vecs[1] = '{13'd3, 16'd2, 1'b1, 1'b0, 1'b0, 12};
        vecs[2] = '{13'd5, 16'd3, 1'b1, 1'b1, 1'b0, 30};
        vecs[3] = '{13'd0, 16'd3, 1'b0, 1'b0, 1'b0, 0};
        vecs[4] = '{13'd4, 16'd0, 1'b1, 1'b0, 1'b0, 0};
        vecs[5] = '{13'd3, 16'd2, 1'b0, 1'b0, 1'b1, 12};
        vecs[6] = '{13'd1, 16'd1, 1'b1, 1'b1, 1'b0, 2};
        vecs[7] = '{13'd2, 16'd4, 1'b0, 1'b1, 1'b0, 16};

        // Reset with live handshakes and a start request: all outputs quiet
        rst_n = 1'b0; cfg_start = 1'b1; cfg_tile_len = 13'd4; cfg_tile_num = 16'd1;
        cfg_identity_en = 1'b1; mac_vld_in = 1'b1; acc_rdy = 1'b1; mac_data_in = 64'h1234;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",    {63'd0, busy},        64'd0);
        chk("rst_done",    {63'd0, done},        64'd0);
        chk("rst_acc_vld", {63'd0, acc_vld},     64'd0);
        chk("rst_mac_rdy", {63'd0, mac_rdy_out}, 64'd0);
        chk("rst_info",    {32'd0, acc_info},    64'd0);
        @(negedge clk);
        rst_n = 1'b1; cfg_start = 1'b0; mac_vld_in = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].len, vecs[i].num, vecs[i].id, vecs[i].rnd, vecs[i].mid, x);
            chk($sformatf("xfer_count_%0d", i), 64'(x), 64'(vecs[i].exp_xfers));
        end

        // Abort a job in the accumulate pass at address 5
        @(negedge clk);
        cfg_start = 1'b1; cfg_tile_len = 13'd8; cfg_tile_num = 16'd1; cfg_identity_en = 1'b1;
        mac_vld_in = 1'b1; acc_rdy = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            #1;
            if (acc_info == 32'h0000_3005) found = 1'b1;
        end
        chk("abort_point_reached", {63'd0, found}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_busy",    {63'd0, busy},    64'd0);
        chk("abort_acc_vld", {63'd0, acc_vld}, 64'd0);
        chk("abort_info",    {32'd0, acc_info}, 64'd0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", {63'd0, seen_done}, 64'd0);
        mac_vld_in = 1'b0;

        // Maximum tile length after the abort
        run_job(13'd4096, 16'd1, 1'b0, 1'b0, 1'b0, x);
        chk("xfer_count_4096", 64'(x), 64'd8192);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
